// File: rtl/l1dc_lsq_responder.sv
// Direct-mapped, blocking L1 D$ responder for the LSQ: fixed-latency answers, refill plus line wake-up on a miss.
// Define L1DC_RESP_MISS_EN to build the tag/valid arrays and the REFILL path; otherwise every access hits.
module l1dc_lsq_responder #(
  parameter int XLEN        = 64,
  parameter int LSQ_IDX_W   = 2,
  parameter int DEPTH_WORDS = 512,
  parameter int LINE_WORDS  = 8,
  parameter int HIT_LAT     = 1,
  parameter int MISS_LAT    = 10
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_is_store_i,
  input  logic [XLEN-1:0]                      req_addr_i,
  input  logic [XLEN-1:0]                      req_data_i,
  input  logic [LSQ_IDX_W-1:0]                 req_lsq_addr_i,
  output logic                                 ans_valid_o,
  output logic [XLEN-1:0]                      ans_data_o,
  output logic                                 ans_was_store_o,
  output logic [LSQ_IDX_W-1:0]                 ans_lsq_addr_o,
  output logic                                 wup_valid_o,
  output logic [XLEN-4-$clog2(LINE_WORDS):0]   wup_line_addr_o
);

  localparam int WORD_W  = $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

`ifdef L1DC_RESP_MISS_EN
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP} state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q;
  logic                 accept, answer;
  logic                 is_store_q;
  logic [XLEN-1:3]      addr_q;
  logic [XLEN-1:0]      data_q;
  logic [LSQ_IDX_W-1:0] lsq_q;
  logic [WORD_W-1:0]    word;
  logic                 hit;
  logic                 unused_bits;

  logic [XLEN-1:0]      mem [DEPTH_WORDS];

  assign word = addr_q[3 +: WORD_W];

`ifdef L1DC_RESP_MISS_EN
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(DEPTH_WORDS / LINE_WORDS);
  localparam int LINES = DEPTH_WORDS / LINE_WORDS;
  localparam int TAG_W = XLEN - 3 - OFF_W - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             wakeup;

  assign idx         = addr_q[3+OFF_W +: IDX_W];
  assign tag         = addr_q[XLEN-1 -: TAG_W];
  assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
  assign unused_bits = ^req_addr_i[2:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= '0;
    else if (wakeup) valid_q[idx] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (wakeup) tag_mem[idx] <= tag;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wup_valid_o     <= 1'b0;
      wup_line_addr_o <= '0;
    end else begin
      wup_valid_o <= wakeup;
      if (wakeup) wup_line_addr_o <= addr_q[XLEN-1:3+OFF_W];
    end
  end
`else
  assign hit             = 1'b1;
  assign wup_valid_o     = 1'b0;
  assign wup_line_addr_o = '0;
  assign unused_bits     = ^{req_addr_i[2:0], addr_q[XLEN-1:3+WORD_W]};
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    answer  = 1'b0;
`ifdef L1DC_RESP_MISS_EN
    wakeup  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
          cnt_d   = CNT_W'(HIT_LAT - 1);
        end
      end
      S_LOOKUP: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (hit) begin
          answer  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef L1DC_RESP_MISS_EN
        else begin
          state_d = S_REFILL;
          cnt_d   = CNT_W'(MISS_LAT - 1);
        end
`endif
      end
`ifdef L1DC_RESP_MISS_EN
      // Flush is deliberately ignored here: the line fill and its wake-up always complete.
      S_REFILL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          wakeup  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  assign req_ready_o = ready_q & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_store_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      lsq_q      <= '0;
    end else if (accept) begin
      is_store_q <= req_is_store_i;
      addr_q     <= req_addr_i[XLEN-1:3];
      data_q     <= req_data_i;
      lsq_q      <= req_lsq_addr_i;
    end
  end

  // The answer is registered on the edge that leaves LOOKUP, so it is visible in the first IDLE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ans_valid_o     <= 1'b0;
      ans_data_o      <= '0;
      ans_was_store_o <= 1'b0;
      ans_lsq_addr_o  <= '0;
    end else begin
      ans_valid_o <= answer;
      if (answer) begin
        ans_data_o      <= is_store_q ? '0 : mem[word];
        ans_was_store_o <= is_store_q;
        ans_lsq_addr_o  <= lsq_q;
      end
    end
  end

  // NOTE: the data array has no reset; its contents survive rst_i and only the valid bits are cleared.
  always_ff @(posedge clk_i) begin
    if (answer && is_store_q) mem[word] <= data_q;
  end

endmodule

// File: tb/tb_l1dc_lsq_responder.sv
// Randomized self-checking bench for l1dc_lsq_responder against a line/word-level cache model.
// Follows L1DC_RESP_MISS_EN the same way as the design.
module tb_l1dc_lsq_responder;

  localparam int HIT_LAT  = 1;
  localparam int MISS_LAT = 10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_is_store_i = 1'b0;
  logic [63:0] req_addr_i = '0;
  logic [63:0] req_data_i = '0;
  logic [1:0]  req_lsq_addr_i = '0;
  logic        ans_valid_o;
  logic [63:0] ans_data_o;
  logic        ans_was_store_o;
  logic [1:0]  ans_lsq_addr_o;
  logic        wup_valid_o;
  logic [57:0] wup_line_addr_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: data words by word index, line state by line index.
  logic [63:0] m_mem [int];
  bit          m_valid [64];
  logic [51:0] m_tag [64];

  l1dc_lsq_responder #(
    .XLEN(64), .LSQ_IDX_W(2), .DEPTH_WORDS(512), .LINE_WORDS(8),
    .HIT_LAT(HIT_LAT), .MISS_LAT(MISS_LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_store_i(req_is_store_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_lsq_addr_i(req_lsq_addr_i),
    .ans_valid_o(ans_valid_o), .ans_data_o(ans_data_o),
    .ans_was_store_o(ans_was_store_o), .ans_lsq_addr_o(ans_lsq_addr_o),
    .wup_valid_o(wup_valid_o), .wup_line_addr_o(wup_line_addr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim_time got=expired want=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit model_hit(input logic [63:0] addr);
`ifdef L1DC_RESP_MISS_EN
    int idx = int'(addr[11:6]);
    return m_valid[idx] && (m_tag[idx] == addr[63:12]);
`else
    return (addr[0] | ~addr[0]);
`endif
  endfunction

  // Issues one request and watches it to completion, comparing against the model.
  task automatic access(input bit st, input logic [63:0] addr, input logic [63:0] data,
                        input logic [1:0] lsq, input int flush_k, input string name,
                        output bit missed);
    int word, nominal, fk, end_k, exp_ans_k, exp_wup_k, ans_k, wup_k, ans_n, wup_n, w;
    bit hit, cancel, known, ready_early, ready_end;
    logic [63:0] exp_data, got_data;
    logic        got_st;
    logic [1:0]  got_lsq;
    logic [57:0] got_line;
    word      = int'(addr[11:3]);
    hit       = model_hit(addr);
    nominal   = hit ? HIT_LAT : HIT_LAT + MISS_LAT;
    fk        = (flush_k < nominal) ? flush_k : -1;
    cancel    = (fk >= 0) && (fk < HIT_LAT);
    end_k     = cancel ? fk + 1 : nominal;
    exp_ans_k = (!cancel && hit) ? HIT_LAT : -1;
    exp_wup_k = (!cancel && !hit) ? HIT_LAT + MISS_LAT : -1;
    known     = st || m_mem.exists(word);
    exp_data  = st ? 64'd0 : (m_mem.exists(word) ? m_mem[word] : 64'd0);
    missed    = 1'b0;

    w = 0;
    @(negedge clk_i);
    while (!req_ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    total_cnt++;
    if (req_ready_o !== 1'b1) begin
      $display("FAIL %s ready_timeout got=%b want=1", name, req_ready_o);
      return;
    end
    pass_cnt++;

    req_valid_i = 1'b1; req_is_store_i = st; req_addr_i = addr;
    req_data_i = data; req_lsq_addr_i = lsq;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;

    ans_k = -1; wup_k = -1; ans_n = 0; wup_n = 0;
    ready_early = 1'b0; ready_end = 1'b0;
    got_data = '0; got_st = 1'b0; got_lsq = '0; got_line = '0;
    for (int k = 0; k <= end_k; k++) begin
      if (k > 0) @(negedge clk_i);
      flush_i = (k == fk);
      #1;
      if (ans_valid_o === 1'b1) begin
        ans_n++;
        if (ans_k < 0) begin
          ans_k = k; got_data = ans_data_o; got_st = ans_was_store_o; got_lsq = ans_lsq_addr_o;
        end
      end
      if (wup_valid_o === 1'b1) begin
        wup_n++;
        if (wup_k < 0) begin
          wup_k = k; got_line = wup_line_addr_o;
        end
      end
      if (k < end_k && req_ready_o !== 1'b0) ready_early = 1'b1;
      if (k == end_k) ready_end = (req_ready_o === 1'b1);
    end
    flush_i = 1'b0;

    total_cnt++;
    if (ans_k != exp_ans_k || ans_n != (exp_ans_k >= 0 ? 1 : 0))
      $display("FAIL %s ans_cycle got=%0d(n=%0d) want=%0d", name, ans_k, ans_n, exp_ans_k);
    else pass_cnt++;
    total_cnt++;
    if (wup_k != exp_wup_k || wup_n != (exp_wup_k >= 0 ? 1 : 0))
      $display("FAIL %s wup_cycle got=%0d(n=%0d) want=%0d", name, wup_k, wup_n, exp_wup_k);
    else pass_cnt++;
    total_cnt++;
    if (ready_early || !ready_end)
      $display("FAIL %s ready_window got=early%0b/end%0b want=early0/end1", name, ready_early, ready_end);
    else pass_cnt++;
    if (exp_ans_k >= 0 && ans_k == exp_ans_k) begin
      total_cnt++;
      if (got_st !== st || got_lsq !== lsq)
        $display("FAIL %s ans_echo got=st%b/tag%0d want=st%b/tag%0d", name, got_st, got_lsq, st, lsq);
      else pass_cnt++;
      if (known) begin
        total_cnt++;
        if (got_data !== exp_data)
          $display("FAIL %s ans_data got=%h want=%h", name, got_data, exp_data);
        else pass_cnt++;
      end
    end
    if (exp_wup_k >= 0 && wup_k == exp_wup_k) begin
      total_cnt++;
      if (got_line !== addr[63:6])
        $display("FAIL %s wup_line got=%h want=%h", name, got_line, addr[63:6]);
      else pass_cnt++;
    end

    if (!cancel) begin
      if (hit && st) m_mem[word] = data;
      if (!hit) begin
        m_valid[int'(addr[11:6])] = 1'b1;
        m_tag[int'(addr[11:6])]   = addr[63:12];
      end
    end
    missed = !cancel && !hit;
  endtask

  // Access that replays after a wake-up, as the LSQ would.
  task automatic access_replay(input bit st, input logic [63:0] addr, input logic [63:0] data,
                               input logic [1:0] lsq, input string name);
    bit missed;
    access(st, addr, data, lsq, -1, name, missed);
    if (missed) access(st, addr, data, lsq, -1, {name, "_replay"}, missed);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    #1;
    total_cnt++;
    if ({ans_valid_o, ans_data_o, ans_was_store_o, ans_lsq_addr_o, wup_valid_o, wup_line_addr_o, req_ready_o} !== '0)
      $display("FAIL reset_outputs got=ans%b/wup%b/rdy%b want=0/0/0", ans_valid_o, wup_valid_o, req_ready_o);
    else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    total_cnt++;
    if (req_ready_o !== 1'b1) $display("FAIL reset_ready_after got=%b want=1", req_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_cold_miss();
    bit missed;
    access(1'b0, 64'h100, 64'd0, 2'd0, -1, "t2_cold_load", missed);
    if (missed) access(1'b0, 64'h100, 64'd0, 2'd0, -1, "t2_cold_load_replay", missed);
    access(1'b0, 64'h200, 64'd0, 2'd3, -1, "t6_cold_load_200", missed);
  endtask

  task automatic test_store_load();
    access_replay(1'b1, 64'h100, 64'hDEAD_BEEF, 2'd1, "t3_store");
    access_replay(1'b0, 64'h100, 64'd0, 2'd2, "t3_load");
    access_replay(1'b0, 64'h104, 64'd0, 2'd0, "t3_load_lowbits_ignored");
  endtask

  task automatic test_conflict();
    access_replay(1'b0, 64'h1100, 64'd0, 2'd1, "t4_conflict_load");
    access_replay(1'b0, 64'h100, 64'd0, 2'd2, "t4_reload_evicted");
  endtask

  task automatic test_flush();
    bit missed;
    int pulses;
    access(1'b0, 64'h108, 64'd0, 2'd0, 0, "t5_flush_lookup", missed);
    access_replay(1'b1, 64'h108, 64'h1234_5678_9ABC_DEF0, 2'd3, "t5_after_flush_store");
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_store_i = 1'b0; req_addr_i = 64'h140; req_lsq_addr_i = 2'd1;
    flush_i = 1'b1;
    #1;
    total_cnt++;
    if (req_ready_o !== 1'b0) $display("FAIL flush_idle_ready got=%b want=0", req_ready_o);
    else pass_cnt++;
    @(negedge clk_i);
    req_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    total_cnt++;
    if (req_ready_o !== 1'b1) $display("FAIL flush_idle_not_accepted got=%b want=1", req_ready_o);
    else pass_cnt++;
    pulses = 0;
    repeat (HIT_LAT + MISS_LAT + 2) begin
      @(negedge clk_i);
      if (ans_valid_o === 1'b1 || wup_valid_o === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL flush_idle_pulses got=%0d want=0", pulses);
    else pass_cnt++;
    access(1'b0, 64'h2180, 64'd0, 2'd2, HIT_LAT + 2, "flush_in_refill", missed);
  endtask

  task automatic test_reset_midop();
    int w, pulses;
`ifdef L1DC_RESP_MISS_EN
    int rst_k = 3;
`else
    int rst_k = 0;
`endif
    w = 0;
    @(negedge clk_i);
    while (!req_ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    req_valid_i = 1'b1; req_is_store_i = 1'b0; req_addr_i = 64'h1C0; req_lsq_addr_i = 2'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (rst_k) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({ans_valid_o, ans_data_o, ans_was_store_o, ans_lsq_addr_o, wup_valid_o, wup_line_addr_o, req_ready_o} !== '0)
      $display("FAIL t1_midop_reset_outputs got=ans%b/wup%b/rdy%b want=0/0/0", ans_valid_o, wup_valid_o, req_ready_o);
    else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    @(posedge clk_i);
    #1;
    total_cnt++;
    if (req_ready_o !== 1'b1) $display("FAIL t1_midop_ready got=%b want=1", req_ready_o);
    else pass_cnt++;
    pulses = 0;
    repeat (HIT_LAT + MISS_LAT + 4) begin
      @(negedge clk_i);
      if (ans_valid_o === 1'b1 || wup_valid_o === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL t1_midop_dropped got=%0d want=0", pulses);
    else pass_cnt++;
    // Array contents survive reset: a warm re-load of 0x100 must return the earlier store.
    access_replay(1'b0, 64'h100, 64'd0, 2'd0, "t1_array_kept");
  endtask

  task automatic test_random();
    bit missed, st;
    logic [63:0] addr, data;
    logic [1:0]  lsq;
    int fk, word;
    for (int i = 0; i < 60; i++) begin
      addr = {50'(64'($urandom_range(0, 2))), 14'd0} >> 2;
      addr = addr | (64'($urandom_range(0, 2) == 0 ? 63 : $urandom_range(4, 5)) << 6)
                  | (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
      word = int'(addr[11:3]);
      st   = ($urandom_range(0, 1) == 1) || !m_mem.exists(word);
      data = {$urandom, $urandom};
      lsq  = 2'($urandom);
      fk   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, HIT_LAT + MISS_LAT - 1) : -1;
      access(st, addr, data, lsq, fk, "rand", missed);
      if (missed) access(st, addr, data, lsq, -1, "rand_replay", missed);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    test_reset();
    test_cold_miss();
    test_store_load();
    test_conflict();
    test_flush();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
